// File: rtl/mem_access_unit.sv
// MAR/MDR register pair with a single-access memory handshake FSM.
// Runs one read or write per start, aborting with a sticky err after TIMEOUT wait cycles.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] bus_in,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        start,
    input  logic        wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    state_e           state_q, state_d;
    logic [15:0]      mar_q, mar_d;
    logic [15:0]      mdr_q, mdr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic             ce_q, ce_d;
    logic             we_q, we_d;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (LD_MAR) mar_d = bus_in;
                if (LD_MDR) mdr_d = bus_in;
                if (start) begin
                    wr_d    = wr;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                // Completion takes priority over timeout on the last allowed cycle.
                if (mem_ready) begin
                    if (!wr_q) mdr_d = mem_rdata;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Strobes are registered from the next state so they align exactly with ACCESS.
        ce_d = (state_d == StAccess);
        we_d = ce_d && wr_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
        end
    end

    assign MAR       = mar_q;
    assign MDR       = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_ce    = ce_q;
    assign mem_we    = we_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule
